// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive-side timing decoder: rebuilds x/y/visible from hsync/vsync,
// checks line/frame geometry, and reports lock, frame pulses and sticky timing errors.
module vga_sync_decoder #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   H_TOTAL     = 800,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   V_TOTAL     = 525,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        err_clr,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        visible,
    output logic        locked,
    output logic        frame_start,
    output logic        hsync_err,
    output logic        vsync_err,
    output logic [15:0] frame_count
);

    localparam logic [11:0] H_SYNC_L  = 12'(H_SYNC);
    localparam logic [11:0] H_TOTAL_L = 12'(H_TOTAL);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_LO  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_HI  = 11'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [10:0] V_SYNC_L  = 11'(V_SYNC);
    localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_LO  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_ACT_HI  = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      state_q;
    logic        hs_q, vs_line_q, hvalid_q, vvalid_q, frame_bad_q;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [9:0]  vw_q, vw_d;
    logic [11:0] hcnt_inc;
    logic [10:0] vcnt_inc;
    logic        hs_now, hs_prev, vs_now, vs_prev;
    logic        h_assert, h_deassert, v_start, v_end;
    logic        h_fail, v_fail, any_fail, lock_next, visible_d;
    logic [9:0]  x_d, y_d;

    always_comb begin
        hs_now     = (hsync == SYNC_ACTIVE);
        hs_prev    = (hs_q == SYNC_ACTIVE);
        vs_now     = (vsync == SYNC_ACTIVE);
        vs_prev    = (vs_line_q == SYNC_ACTIVE);
        h_assert   = hs_now & ~hs_prev;
        h_deassert = ~hs_now & hs_prev;
        hcnt_inc   = {1'b0, hcnt_q} + 12'd1;
        vcnt_inc   = {1'b0, vcnt_q} + 11'd1;
        hcnt_d     = h_assert ? 11'd0 : ((hcnt_q == 11'h7FF) ? hcnt_q : hcnt_inc[10:0]);

        // Vertical state only advances on line boundaries (hsync assert edges).
        v_start = h_assert & vs_now & ~vs_prev;
        v_end   = h_assert & ~vs_now & vs_prev;
        vcnt_d  = vcnt_q;
        vw_d    = vw_q;
        if (h_assert) begin
            vcnt_d = v_start ? 10'd0 : ((vcnt_q == 10'h3FF) ? vcnt_q : vcnt_inc[9:0]);
            if (vs_now) begin
                vw_d = v_start ? 10'd1 : ((vw_q == 10'h3FF) ? vw_q : vw_q + 10'd1);
            end
        end

        // Width/period checks need one full reference edge first; timeouts do not.
        h_fail = (hvalid_q & h_deassert & (hcnt_inc != H_SYNC_L))
               | (hvalid_q & h_assert & (hcnt_inc != H_TOTAL_L))
               | (~h_assert & (hcnt_q == H_LAST));
        v_fail = (vvalid_q & v_end & ({1'b0, vw_q} != V_SYNC_L))
               | (vvalid_q & v_start & (vcnt_inc != V_TOTAL_L))
               | (h_assert & ~v_start & (vcnt_q == V_LAST));
        any_fail = h_fail | v_fail;

        lock_next = ((state_q == LOCKED) & ~any_fail)
                  | ((state_q == ACQUIRE) & v_start & ~frame_bad_q & ~any_fail);
        visible_d = lock_next & (hcnt_d >= H_ACT_LO) & (hcnt_d <= H_ACT_HI)
                              & (vcnt_d >= V_ACT_LO) & (vcnt_d <= V_ACT_HI);
        x_d = visible_d ? 10'(hcnt_d - H_ACT_LO) : 10'd0;
        y_d = visible_d ? (vcnt_d - V_ACT_LO) : 10'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            hs_q        <= ~SYNC_ACTIVE;
            vs_line_q   <= ~SYNC_ACTIVE;
            hvalid_q    <= 1'b0;
            vvalid_q    <= 1'b0;
            frame_bad_q <= 1'b0;
            hcnt_q      <= 11'd0;
            vcnt_q      <= 10'd0;
            vw_q        <= 10'd0;
            x           <= 10'd0;
            y           <= 10'd0;
            visible     <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            hsync_err   <= 1'b0;
            vsync_err   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            frame_start <= 1'b0;
            // A fresh error outranks a simultaneous clear.
            hsync_err   <= (p_tick & h_fail) | (hsync_err & ~err_clr);
            vsync_err   <= (p_tick & v_fail) | (vsync_err & ~err_clr);
            if (p_tick) begin
                hs_q    <= hsync;
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                vw_q    <= vw_d;
                locked  <= lock_next;
                visible <= visible_d;
                x       <= x_d;
                y       <= y_d;
                if (h_assert) begin
                    hvalid_q  <= 1'b1;
                    vs_line_q <= vsync;
                end
                if (v_start) vvalid_q <= 1'b1;
                case (state_q)
                    SEARCH: begin
                        if (v_start) begin
                            state_q     <= ACQUIRE;
                            frame_bad_q <= 1'b0;
                        end
                    end
                    ACQUIRE: begin
                        if (v_start) begin
                            if (frame_bad_q | any_fail) begin
                                frame_bad_q <= 1'b0;
                            end else begin
                                state_q     <= LOCKED;
                                frame_start <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                            end
                        end else if (any_fail) begin
                            frame_bad_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        // The frame in flight is tainted, so relock needs a further clean frame.
                        if (any_fail) begin
                            state_q     <= ACQUIRE;
                            frame_bad_q <= 1'b1;
                        end else if (v_start) begin
                            frame_start <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - Self-checking bench for vga_sync_decoder on a reduced geometry.
module tb_vga_sync_decoder;

    localparam int HV = 16, HS = 4, HB = 3, HT = 26;
    localparam int VV = 6,  VS = 2, VB = 2, VT = 13;
    localparam int HLO = HS + HB, VLO = VS + VB;

    logic        clk = 1'b0, reset = 1'b0, p_tick = 1'b0;
    logic        hsync = 1'b1, vsync = 1'b1, err_clr = 1'b0;
    logic [9:0]  x, y;
    logic        visible, locked, frame_start, hsync_err, vsync_err;
    logic [15:0] frame_count;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
        .err_clr(err_clr), .x(x), .y(y), .visible(visible), .locked(locked),
        .frame_start(frame_start), .hsync_err(hsync_err), .vsync_err(vsync_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int gh = 0, gv = 0, short_v = -1, pending = 2;
    bit short_frame = 0, prev_short = 0, hs_off = 0, hs_off_seen = 0;
    bit exp_locked = 0, exp_herr = 0, exp_verr = 0, exp_fs = 0;
    logic [15:0] exp_frames = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel tick of an ideal generator whose coordinates start at the sync assert edges.
    task automatic tick(input bit clr = 0);
        int  idle;
        bit  start, hev, vev, vis;
        idle = $urandom_range(0, 3);
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            if (i == 0) chk("fs_return_low", frame_start, 0);
        end
        @(negedge clk);
        hsync   = (!hs_off && gh < ((gv == short_v) ? HS - 1 : HS)) ? 1'b0 : 1'b1;
        vsync   = (gv < VS) ? 1'b0 : 1'b1;
        p_tick  = 1'b1;
        err_clr = clr;
        start = !hs_off && gh == 0 && gv == 0;
        hev   = (gv == short_v && gh == HS - 1) || (hs_off && !hs_off_seen && gh == 0);
        vev   = start && prev_short;
        exp_fs = 0;
        if (hev || vev) begin
            exp_locked = 0;
            pending    = 2;
            if (hev) exp_herr = 1;
            if (vev) exp_verr = 1;
        end else if (start) begin
            if (pending > 0) pending--;
            if (pending == 0) begin
                exp_locked = 1;
                exp_fs     = 1;
                exp_frames = exp_frames + 16'd1;
            end
        end
        if (hs_off && gh == 0) hs_off_seen = 1;
        if (vev) prev_short = 0;
        if (clr && !hev) exp_herr = 0;
        if (clr && !vev) exp_verr = 0;
        @(negedge clk);
        p_tick  = 1'b0;
        err_clr = 1'b0;
        vis = exp_locked && gh >= HLO && gh < HLO + HV && gv >= VLO && gv < VLO + VV;
        chk("locked", locked, exp_locked);
        chk("visible", visible, vis);
        chk("x", x, vis ? gh - HLO : 0);
        chk("y", y, vis ? gv - VLO : 0);
        chk("frame_start", frame_start, exp_fs);
        chk("frame_count", frame_count, exp_frames);
        chk("hsync_err", hsync_err, exp_herr);
        chk("vsync_err", vsync_err, exp_verr);
        if (gh == HT - 1) begin
            gh = 0;
            if (gv == short_v) short_v = -1;
            if (gv == (short_frame ? VT - 2 : VT - 1)) begin
                gv          = 0;
                prev_short  = short_frame;
                short_frame = 0;
            end else begin
                gv++;
            end
        end else begin
            gh++;
        end
    endtask

    task automatic run_to(input int tv, input int th);
        int n = 0;
        while (!(gv == tv && gh == th) && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        assert (gv == tv && gh == th) else begin
            errors++;
            $error("FAIL run_to observed=%0d,%0d expected=%0d,%0d", gv, gh, tv, th);
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr  = 1'b0;
        exp_herr = 0;
        exp_verr = 0;
        chk("clr_hsync_err", hsync_err, 0);
        chk("clr_vsync_err", vsync_err, 0);
    endtask

    task automatic relock();
        run_to(0, 0); tick();
        chk("relock_pending", locked, 0);
        run_to(0, 0); tick();
        chk("relock_done", locked, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_vis"}, visible, 0);
        chk({tag, "_lock"}, locked, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_herr"}, hsync_err, 0);
        chk({tag, "_verr"}, vsync_err, 0);
        chk({tag, "_fcnt"}, frame_count, 0);
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Clean frames: first vsync start acquires, second locks.
        tick();
        chk("acquire_not_locked", locked, 0);
        run_to(0, 0); tick();
        chk("lock_at_2nd_start", locked, 1);
        chk("first_frame_count", frame_count, 1);
        run_to(VLO, HLO); tick();
        chk("corner0_vis", visible, 1);
        chk("corner0_x", x, 0);
        chk("corner0_y", y, 0);
        run_to(VLO + VV - 1, HLO + HV - 1); tick();
        chk("corner1_x", x, HV - 1);
        chk("corner1_y", y, VV - 1);

        // Short hsync pulse while locked.
        run_to(4, 0);
        short_v = 4;
        run_to(4, HS);
        chk("short_h_err", hsync_err, 1);
        chk("short_h_unlock", locked, 0);
        relock();
        chk("herr_sticky", hsync_err, 1);
        clear_err();

        // Short pulse coincident with err_clr: the new error must survive.
        run_to(3, HS - 1);
        short_v = 3;
        tick(1);
        chk("err_beats_clr", hsync_err, 1);
        relock();
        clear_err();

        // Frame one line short.
        short_frame = 1;
        run_to(0, 0); tick();
        chk("short_v_err", vsync_err, 1);
        chk("short_v_no_fs", frame_start, 0);
        relock();
        clear_err();

        // Reset mid-line while locked.
        run_to(5, 10);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        exp_locked = 0; pending = 2; exp_frames = 16'd0;
        relock();
        chk("post_reset_count", frame_count, 1);

        // Hsync stops: timeout at the line length, then the counter must saturate, not wrap.
        run_to(2, 0);
        hs_off = 1;
        tick();
        chk("timeout_err", hsync_err, 1);
        chk("timeout_unlock", locked, 0);
        clear_err();
        repeat (2100) tick();
        chk("saturate_no_retrigger", hsync_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
